// File: rtl/led_frame_sched.sv
// Buffers GRB bytes for an LED chain and streams them to the bit encoder on commit; optional LED_AUTO_REFRESH_EN self-commits when idle.
// Latency: commit at N -> first byte valid at N+2; each byte held until byte_ready_i, then the next follows with no bubble.
module led_frame_sched #(
  parameter int LED_CNT        = 3,
  parameter int GAP_CYCLES     = 2500,
  parameter int REFRESH_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  input  logic       commit_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int DEPTH = LED_CNT * 3;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0]    LAST_ADDR = 8'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    buf_mem [DEPTH];
  logic [IW-1:0] idx, idx_nxt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    byte_q, rd_q;
  logic          byte_vld_q, pending, frame_done, xfer, frame_start, commit_req;

  assign xfer        = byte_vld_q & byte_ready_i;
  assign idx_nxt     = idx + IW'(1);
  assign frame_start = (state_nxt == LOAD);

`ifdef LED_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [RW-1:0] ref_cnt;
  logic          auto_commit;

  assign auto_commit = (state == IDLE) && (ref_cnt == RW'(REFRESH_CYCLES - 1));
  assign commit_req  = commit_i | auto_commit;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ref_cnt <= '0;
    else if (frame_start)
      ref_cnt <= '0;
    else if (state == IDLE)
      ref_cnt <= ref_cnt + RW'(1);
  end
`else
  assign commit_req = commit_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE: if (commit_req) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (xfer && idx == LAST_IDX) state_nxt = GAP;
      GAP: begin
        if (gap_cnt == GW'(1)) begin
          frame_done = 1'b1;
          state_nxt  = (pending || commit_req) ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= 8'h00;
      rd_q       <= 8'h00;
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      idx        <= '0;
      gap_cnt    <= '0;
      pending    <= 1'b0;
    end else begin
      if (wr_en_i && wr_addr_i <= LAST_ADDR)
        buf_mem[wr_addr_i[IW-1:0]] <= wr_data_i;
      rd_q <= (rd_addr_i <= LAST_ADDR) ? buf_mem[rd_addr_i[IW-1:0]] : 8'h00;

      // A commit arriving while a frame runs (including its done cycle) is held for one re-send.
      if (frame_start)
        pending <= 1'b0;
      else if (commit_req && state != IDLE)
        pending <= 1'b1;

      case (state)
        LOAD: begin
          idx        <= '0;
          byte_q     <= buf_mem[0];
          byte_vld_q <= 1'b1;
        end
        SEND: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              byte_vld_q <= 1'b0;
              gap_cnt    <= GW'(GAP_CYCLES);
            end else begin
              idx    <= idx_nxt;
              byte_q <= buf_mem[idx_nxt];
            end
          end
        end
        GAP:     gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

  assign rd_data_o    = rd_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = byte_vld_q;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = frame_done;

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched: scoreboard of expected bytes, timing and stall checks.
module tb_led_frame_sched;
  localparam int LED_CNT = 3;
  localparam int GAP     = 20;
  localparam int NB      = LED_CNT * 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_addr_i = 8'h00;
  logic [7:0] wr_data_i = 8'h00;
  logic [7:0] rd_addr_i = 8'h00;
  logic [7:0] rd_data_o;
  logic       commit_i = 1'b0;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i = 1'b0;
  logic       busy_o;
  logic       frame_done_o;

  led_frame_sched #(.LED_CNT(LED_CNT), .GAP_CYCLES(GAP), .REFRESH_CYCLES(300)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .commit_i(commit_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nxfer = 0, ndone = 0;
  int first_vld_cyc = -1, last_xfer_cyc = -1, done_cyc = -1;
  logic prev_vld = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] sb [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_vld", int'(byte_valid_o), 1);
        chk("stall_dat", int'(byte_o), int'(prev_byte));
      end
      if (byte_valid_o && !prev_vld) first_vld_cyc = cyc;
      if (byte_valid_o && byte_ready_i) begin
        nxfer++;
        last_xfer_cyc = cyc;
        if (sb.size() == 0) begin
          total++; bad++;
          $error("FAIL extra_byte observed=%0h expected=none", byte_o);
        end else begin
          chk("byte_order", int'(byte_o), int'(sb.pop_front()));
        end
      end
      if (frame_done_o) begin
        ndone++;
        done_cyc = cyc;
        chk("gap_len", cyc - last_xfer_cyc, GAP);
      end
    end
    prev_vld   = byte_valid_o;
    prev_stall = byte_valid_o && !byte_ready_i && rst_n;
    prev_byte  = byte_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    step(1);
    wr_en_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input int exp, input string tag);
    rd_addr_i = a;
    step(1);
    chk(tag, int'(rd_data_o), exp);
  endtask

  task automatic push_frame(input logic [7:0] base);
    for (int i = 0; i < NB; i++) sb.push_back(base + 8'(i));
  endtask

  task automatic wait_done(input int lim, input bit rand_rdy);
    int base = ndone;
    int n = 0;
    while (ndone == base && n < lim) begin
      if (rand_rdy) byte_ready_i = 1'($urandom_range(0, 1));
      step(1);
      n++;
    end
    if (ndone == base) begin
      total++; bad++;
      $error("FAIL timeout_done observed=%0d expected<%0d", n, lim);
    end
  endtask

  initial begin
    int commit_cyc, base_x, base_d, n;

    // 1: reset
    step(2);
    chk("rst_vld",  int'(byte_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(frame_done_o), 0);
    chk("rst_byte", int'(byte_o), 0);
    chk("rst_rd",   int'(rd_data_o), 0);
    rst_n = 1'b1;
    for (int i = 0; i < NB; i++) rd(8'(i), 0, "rst_buf");

    // 2: basic frame, ready always high
    for (int i = 0; i < NB; i++) wr(8'(i), 8'h11 + 8'(i));
    rd(8'd4, 8'h15, "rd_back");
    push_frame(8'h11);
    byte_ready_i = 1'b1;
    base_x = nxfer;
    commit_i = 1'b1; commit_cyc = cyc;
    step(1);
    commit_i = 1'b0;
    chk("busy_n1", int'(busy_o), 1);
    chk("vld_n1",  int'(byte_valid_o), 0);
    wait_done(200, 1'b0);
    chk("busy_fall",  int'(busy_o), 0);
    chk("vld_lat",    first_vld_cyc, commit_cyc + 2);
    chk("no_bubble",  last_xfer_cyc - first_vld_cyc, NB - 1);
    chk("xfer_cnt",   nxfer - base_x, NB);
    chk("sb_empty_2", sb.size(), 0);

    // 3: random backpressure
    for (int i = 0; i < NB; i++) wr(8'(i), 8'h21 + 8'(i));
    push_frame(8'h21);
    base_x = nxfer;
    commit_i = 1'b1;
    step(1);
    commit_i = 1'b0;
    wait_done(2000, 1'b1);
    chk("xfer_cnt_3", nxfer - base_x, NB);
    chk("sb_empty_3", sb.size(), 0);

    // 4: two commits during SEND merge into one extra frame
    byte_ready_i = 1'b1;
    push_frame(8'h21);
    push_frame(8'h21);
    base_d = ndone;
    commit_i = 1'b1;
    step(1);
    commit_i = 1'b0;
    step(1);
    commit_i = 1'b1;
    step(1);
    commit_i = 1'b0;
    step(1);
    commit_i = 1'b1;
    step(1);
    commit_i = 1'b0;
    wait_done(200, 1'b0);
    chk("busy_rearm", int'(busy_o), 1);
    wait_done(200, 1'b0);
    chk("next_start", first_vld_cyc, done_cyc - GAP - (NB - 1) );
    chk("busy_end",   int'(busy_o), 0);
    step(GAP + 20);
    chk("done_cnt_4", ndone - base_d, 2);
    chk("sb_empty_4", sb.size(), 0);

    // 5: out-of-range access
    wr(8'd9, 8'hAA);
    wr(8'd255, 8'hBB);
    rd(8'd200, 0, "rd_oor");
    rd(8'd9, 0, "rd_addr9");
    for (int i = 0; i < NB; i++) rd(8'(i), 8'h21 + i, "buf_keep");

    // 6: reset in the middle of SEND
    push_frame(8'h21);
    base_x = nxfer;
    base_d = ndone;
    commit_i = 1'b1;
    step(1);
    commit_i = 1'b0;
    n = 0;
    while (nxfer - base_x < 4 && n < 100) begin
      step(1);
      n++;
    end
    chk("xfer4_reached", nxfer - base_x, 4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("abort_vld",  int'(byte_valid_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_left", sb.size(), NB - 4);
    sb.delete();
    step(GAP + 20);
    chk("abort_nodone", ndone - base_d, 0);
    chk("abort_idle",   int'(byte_valid_o), 0);
    rd(8'd0, 0, "abort_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
